// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef logic port_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LAST0 = 2'd1,
        LAST1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, response and memory-side signals of the arbiter; slave = arbiter view.
interface mem_arbiter_if import mem_arb_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          req0,   req1;
    logic          we0,    we1;
    logic [AW-1:0] addr0,  addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0,   gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    arb_state_t    arb_state;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_addr, mem_wdata, mem_we,
        output arb_state
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_addr, mem_wdata, mem_we,
        input  arb_state
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way winner select: a lone requester always wins, a tie goes to prio.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || prio == 1'b0)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single-port synchronous-read memory.
// MEM_ARBITER_FIXED_PRIO_EN: port 0 always wins ties; otherwise round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    arb_state_t    state;
    logic [1:0]    req_v;
    logic [1:0]    gnt_raw;
    logic [1:0]    gnt;
    logic          accept;
    port_id_t      win_id;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    port_id_t      tie_pref;

    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_we_q;

    // Read-return pipeline: stage 1 lines up with the address at the memory,
    // stage 2 with the memory's registered read data.
    logic          s1_v, s2_v;
    port_id_t      s1_id, s2_id;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    assign tie_pref = 1'b0;
`else
    port_id_t last_win;

    // Last winner survives idle cycles so fairness spans gaps in traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_win <= 1'b1;
        end else if (accept) begin
            last_win <= win_id;
        end
    end

    assign tie_pref = ~last_win;
`endif

    assign req_v = {bus.req1, bus.req0};

    mem_arb_pick u_pick (
        .req  (req_v),
        .prio (tie_pref),
        .gnt  (gnt_raw)
    );

    assign gnt       = rst_n ? gnt_raw : 2'b00;
    assign accept    = |gnt;
    assign win_id    = gnt[1];
    assign win_we    = win_id ? bus.we1    : bus.we0;
    assign win_addr  = win_id ? bus.addr1  : bus.addr0;
    assign win_wdata = win_id ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            s1_v        <= 1'b0;
            s1_id       <= 1'b0;
            s2_v        <= 1'b0;
            s2_id       <= 1'b0;
        end else begin
            s2_v     <= s1_v;
            s2_id    <= s1_id;
            s1_v     <= accept & ~win_we;
            s1_id    <= win_id;
            mem_we_q <= accept & win_we;
            if (accept) begin
                mem_addr_q  <= win_addr;
                mem_wdata_q <= win_wdata;
                state       <= win_id ? LAST1 : LAST0;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.gnt0      = gnt[0];
    assign bus.gnt1      = gnt[1];
    assign bus.rvalid0   = s2_v & (s2_id == 1'b0);
    assign bus.rvalid1   = s2_v & (s2_id == 1'b1);
    assign bus.rdata0    = bus.mem_rdata;
    assign bus.rdata1    = bus.mem_rdata;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.arb_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table plus a read-response scoreboard.
// Expected tie winners follow MEM_ARBITER_FIXED_PRIO_EN when it is defined.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        bit          rst_n;
        bit          r0, w0;
        logic [15:0] a0, d0;
        bit          r1, w1;
        logic [15:0] a1, d1;
        bit          g0, g1;
    } vec_t;

    typedef struct {
        bit          port;
        logic [15:0] data;
        int          due;
    } rd_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_total;
    int   n_pass;
    bit   chk_on;

    mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_arbiter #(.AW(16), .DW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return a ^ 16'hC3A5;
    endfunction

    // Memory with one-cycle synchronous read; unwritten words read init_val.
    logic [15:0] mem  [0:65535];
    bit          wr_f [0:65535];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr]  <= bus.mem_wdata;
            wr_f[bus.mem_addr] <= 1'b1;
        end
        bus.mem_rdata <= wr_f[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
    end

    logic [15:0] model_mem [int];
    rd_t         sb [$];
    vec_t        tbl [$];

    arb_state_t  exp_st;
    logic        exp_we;
    logic [15:0] exp_addr, exp_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t row(input bit rn,
                                 input bit r0, input bit w0, input logic [15:0] a0, input logic [15:0] d0,
                                 input bit r1, input bit w1, input logic [15:0] a1, input logic [15:0] d1,
                                 input bit g0, input bit g1);
        vec_t v;
        v.rst_n = rn;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    function automatic vec_t idle_row();
        return row(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
    endfunction

    function automatic vec_t rst_row();
        return row(0, 1, 0, 16'h00AA, 16'h0, 1, 1, 16'h00BB, 16'h5555, 0, 0);
    endfunction

    task automatic step(input vec_t v);
        rd_t         it;
        bit          acc, win, we;
        logic [15:0] a, d, md;
        @(posedge clk);
        #1;
        rst_n      = v.rst_n;
        bus.req0   = v.r0;  bus.we0 = v.w0;  bus.addr0 = v.a0;  bus.wdata0 = v.d0;
        bus.req1   = v.r1;  bus.we1 = v.w1;  bus.addr1 = v.a1;  bus.wdata1 = v.d1;
        @(negedge clk);
        chk("gnt", {30'd0, bus.gnt1, bus.gnt0}, {30'd0, v.g1, v.g0});
        if (chk_on) begin
            chk("state", 32'(bus.arb_state), 32'(exp_st));
            chk("mem_we", {31'd0, bus.mem_we}, {31'd0, exp_we});
            chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, exp_addr});
            chk("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, exp_wdata});
            if (sb.size() > 0 && sb[0].due == cyc) begin
                it = sb.pop_front();
                chk("rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, it.port ? 32'd2 : 32'd1);
                chk("rdata0", {16'd0, bus.rdata0}, {16'd0, it.data});
                chk("rdata1", {16'd0, bus.rdata1}, {16'd0, it.data});
            end else begin
                chk("rvalid_idle", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
            end
        end
        acc = v.rst_n && (v.g0 || v.g1);
        if (acc) begin
            win = v.g1;
            we  = win ? v.w1 : v.w0;
            a   = win ? v.a1 : v.a0;
            d   = win ? v.d1 : v.d0;
            if (we) begin
                model_mem[int'(a)] = d;
            end else begin
                md = model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_val(a);
                sb.push_back('{port: win, data: md, due: cyc + 2});
            end
            exp_we    = we;
            exp_addr  = a;
            exp_wdata = d;
            exp_st    = win ? LAST1 : LAST0;
        end else begin
            exp_we = 1'b0;
            exp_st = IDLE;
        end
        if (!v.rst_n) begin
            sb.delete();
            exp_we    = 1'b0;
            exp_addr  = 16'h0;
            exp_wdata = 16'h0;
            exp_st    = IDLE;
            chk_on    = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0; n_pass = 0; chk_on = 1'b0;
        exp_st = IDLE; exp_we = 1'b0; exp_addr = 16'h0; exp_wdata = 16'h0;
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

        // Reset, then a lone port-0 read of the BEEF word.
        tbl.push_back(rst_row());
        tbl.push_back(rst_row());
        tbl.push_back(row(1, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(idle_row());

        // Fresh pointer, both ports read every cycle for six cycles.
        tbl.push_back(rst_row());
        for (int i = 0; i < 6; i++) begin
            bit g1;
            g1 = !FIXED && ((i % 2) == 1);
            tbl.push_back(row(1, 1, 0, 16'h0020, 16'h0, 1, 0, 16'h0030, 16'h0, !g1, g1));
        end
        for (int i = 0; i < 3; i++) tbl.push_back(idle_row());

        // Port 1 write followed immediately by a port 0 read of the same word.
        tbl.push_back(row(1, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0005, 16'h1234, 0, 1));
        tbl.push_back(row(1, 1, 0, 16'h0005, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(idle_row());

        // Back-to-back reads from alternating ports.
        tbl.push_back(row(1, 1, 0, 16'h0001, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0));
        tbl.push_back(row(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(idle_row());

        // Tie, loser withdraws, lone requests, write tie and read-back.
        tbl.push_back(row(1, 1, 0, 16'h0040, 16'h0, 1, 0, 16'h0041, 16'h0, 1, 0));
        tbl.push_back(idle_row());
        tbl.push_back(row(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0041, 16'h0, 0, 1));
        tbl.push_back(row(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0042, 16'h0, 0, 1));
        tbl.push_back(row(1, 1, 1, 16'h0050, 16'hAAAA, 1, 1, 16'h0051, 16'hBBBB, 1, 0));
        tbl.push_back(row(1, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0051, 16'hBBBB, 0, 1));
        tbl.push_back(row(1, 1, 0, 16'h0050, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0));
        tbl.push_back(row(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0051, 16'h0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(idle_row());

        foreach (tbl[i]) step(tbl[i]);

        // Reset one cycle after a read accept: the read must vanish and the
        // next tie must go to port 0 even though port 0 won last.
        step(row(1, 1, 0, 16'h0060, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0));
        step(rst_row());
        for (int i = 0; i < 3; i++) step(idle_row());
        step(row(1, 1, 0, 16'h0070, 16'h0, 1, 0, 16'h0071, 16'h0, 1, 0));
        step(row(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0071, 16'h0, 0, 1));
        for (int i = 0; i < 3; i++) step(idle_row());

        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
